// File: rtl/kp_color_threshold.sv
// rtl/kp_color_threshold.sv - RGB565 colour-window threshold with masked output and per-frame bounding box
// Build option: define KP_THRESH_BINARY_EN for a binary 16'hFFFF/16'h0000 mask in enabled mode.
module kp_color_threshold #(
  parameter int LINE_LENGTH = 480,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 16,
  localparam int XW = $clog2(LINE_LENGTH),
  localparam int YW = $clog2(LINE_COUNT),
  localparam int CW = $clog2(LINE_LENGTH * LINE_COUNT) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_almostempty,
  output logic                  o_rd,
  input  logic                  i_almostfull,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic [4:0]            i_rmin,
  input  logic [4:0]            i_rmax,
  input  logic [5:0]            i_gmin,
  input  logic [5:0]            i_gmax,
  input  logic [4:0]            i_bmin,
  input  logic [4:0]            i_bmax,
  output logic                  o_bbox_valid,
  output logic                  o_bbox_found,
  output logic [XW-1:0]         o_xmin,
  output logic [XW-1:0]         o_xmax,
  output logic [YW-1:0]         o_ymin,
  output logic [YW-1:0]         o_ymax,
  output logic [CW-1:0]         o_match_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic            rd_d;
  logic            can_read;
  logic            din_valid;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [4:0]      rmin_q, rmax_q, bmin_q, bmax_q;
  logic [5:0]      gmin_q, gmax_q;
  logic [4:0]      r_lo, r_hi, b_lo, b_hi;
  logic [5:0]      g_lo, g_hi;
  logic [4:0]      pix_r, pix_b;
  logic [5:0]      pix_g;
  logic            first_px, last_x, last_px, match;
  logic [DATA_WIDTH-1:0] masked, pix_out;
  logic [XW-1:0]   acc_xmin, acc_xmax, nx_xmin, nx_xmax;
  logic [YW-1:0]   acc_ymin, acc_ymax, nx_ymin, nx_ymax;
  logic [CW-1:0]   acc_count, nx_count;

  assign can_read = !i_almostempty && !i_almostfull;

  // Read FSM: keep reading while upstream has data and downstream has room
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_read) begin
          state_d = ACTIVE;
          rd_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (can_read) rd_d = 1'b1;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered read strobe
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      o_rd    <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      o_rd    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_rd    <= rd_d;
    end
  end

  // Read data arrives one cycle after the strobe
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)      din_valid <= 1'b0;
    else if (i_flush) din_valid <= 1'b0;
    else              din_valid <= o_rd;
  end

  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_x   = (x_q == XW'(LINE_LENGTH - 1));
  assign last_px  = last_x && (y_q == YW'(LINE_COUNT - 1));

  // The first pixel of a frame sees the live thresholds it is about to latch
  assign r_lo = first_px ? i_rmin : rmin_q;
  assign r_hi = first_px ? i_rmax : rmax_q;
  assign g_lo = first_px ? i_gmin : gmin_q;
  assign g_hi = first_px ? i_gmax : gmax_q;
  assign b_lo = first_px ? i_bmin : bmin_q;
  assign b_hi = first_px ? i_bmax : bmax_q;

  assign pix_r = i_data[15:11];
  assign pix_g = i_data[10:5];
  assign pix_b = i_data[4:0];

  assign match = i_enable &&
                 (pix_r >= r_lo) && (pix_r <= r_hi) &&
                 (pix_g >= g_lo) && (pix_g <= g_hi) &&
                 (pix_b >= b_lo) && (pix_b <= b_hi);

`ifdef KP_THRESH_BINARY_EN
  assign masked = match ? '1 : '0;
`else
  assign masked = match ? i_data : '0;
`endif
  assign pix_out = i_enable ? masked : i_data;

  // Merge the current pixel's match into the running box and count
  always_comb begin
    nx_xmin  = acc_xmin;
    nx_xmax  = acc_xmax;
    nx_ymin  = acc_ymin;
    nx_ymax  = acc_ymax;
    nx_count = acc_count;
    if (match) begin
      nx_count = acc_count + 1'b1;
      if (acc_count == '0) begin
        nx_xmin = x_q;
        nx_xmax = x_q;
        nx_ymin = y_q;
        nx_ymax = y_q;
      end else begin
        if (x_q < acc_xmin) nx_xmin = x_q;
        if (x_q > acc_xmax) nx_xmax = x_q;
        if (y_q < acc_ymin) nx_ymin = y_q;
        if (y_q > acc_ymax) nx_ymax = y_q;
      end
    end
  end

  // Raster position and frame-start threshold shadows
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || i_flush) begin
      x_q    <= '0;
      y_q    <= '0;
      rmin_q <= '0;
      rmax_q <= '0;
      gmin_q <= '0;
      gmax_q <= '0;
      bmin_q <= '0;
      bmax_q <= '0;
    end else if (din_valid) begin
      if (first_px) begin
        rmin_q <= i_rmin;
        rmax_q <= i_rmax;
        gmin_q <= i_gmin;
        gmax_q <= i_gmax;
        bmin_q <= i_bmin;
        bmax_q <= i_bmax;
      end
      if (last_x) begin
        x_q <= '0;
        y_q <= last_px ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Output pixel register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || i_flush) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= din_valid;
      if (din_valid) o_data <= pix_out;
    end
  end

  // Frame accumulators; publish the box alongside the last pixel of the frame
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || i_flush) begin
      acc_xmin      <= '0;
      acc_xmax      <= '0;
      acc_ymin      <= '0;
      acc_ymax      <= '0;
      acc_count     <= '0;
      o_bbox_valid  <= 1'b0;
      o_bbox_found  <= 1'b0;
      o_xmin        <= '0;
      o_xmax        <= '0;
      o_ymin        <= '0;
      o_ymax        <= '0;
      o_match_count <= '0;
    end else begin
      o_bbox_valid <= 1'b0;
      if (din_valid) begin
        if (last_px) begin
          o_bbox_valid  <= 1'b1;
          o_bbox_found  <= (nx_count != '0);
          o_xmin        <= nx_xmin;
          o_xmax        <= nx_xmax;
          o_ymin        <= nx_ymin;
          o_ymax        <= nx_ymax;
          o_match_count <= nx_count;
          acc_xmin      <= '0;
          acc_xmax      <= '0;
          acc_ymin      <= '0;
          acc_ymax      <= '0;
          acc_count     <= '0;
        end else begin
          acc_xmin  <= nx_xmin;
          acc_xmax  <= nx_xmax;
          acc_ymin  <= nx_ymin;
          acc_ymax  <= nx_ymax;
          acc_count <= nx_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_kp_color_threshold.sv
// tb/tb_kp_color_threshold.sv - self-checking bench for kp_color_threshold
module tb_kp_color_threshold;

  localparam int LL = 4;
  localparam int LC = 2;
  localparam int FR = LL * LC;
  localparam int XW = $clog2(LL);
  localparam int YW = $clog2(LC);
  localparam int CW = $clog2(FR) + 1;

  logic          i_clk, i_rstn, i_enable, i_flush;
  logic [15:0]   i_data;
  logic          i_almostempty, i_almostfull;
  logic          o_rd, o_valid;
  logic [15:0]   o_data;
  logic [4:0]    i_rmin, i_rmax, i_bmin, i_bmax;
  logic [5:0]    i_gmin, i_gmax;
  logic          o_bbox_valid, o_bbox_found;
  logic [XW-1:0] o_xmin, o_xmax;
  logic [YW-1:0] o_ymin, o_ymax;
  logic [CW-1:0] o_match_count;

  kp_color_threshold #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_flush(i_flush),
    .i_data(i_data), .i_almostempty(i_almostempty), .o_rd(o_rd),
    .i_almostfull(i_almostfull), .o_data(o_data), .o_valid(o_valid),
    .i_rmin(i_rmin), .i_rmax(i_rmax), .i_gmin(i_gmin), .i_gmax(i_gmax),
    .i_bmin(i_bmin), .i_bmax(i_bmax), .o_bbox_valid(o_bbox_valid),
    .o_bbox_found(o_bbox_found), .o_xmin(o_xmin), .o_xmax(o_xmax),
    .o_ymin(o_ymin), .o_ymax(o_ymax), .o_match_count(o_match_count)
  );

  typedef struct {
    logic [15:0] data;
    bit          eof;
    logic [10:0] box;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests, fails, cyc;
  logic [15:0] src[0:255];
  int          rd_log[0:255];
  int          src_len, ptr;
  logic [15:0] out_log[0:255];
  int          out_cyc[0:255];
  int          out_n;
  bit          force_ae, pres_valid, rd_seen;
  logic [15:0] cur_pix;
  int          cur_rc, seen_cyc;
  int          pos, m_count, mx0, mx1, my0, my1;
  int          sh_rmin, sh_rmax, sh_gmin, sh_gmax, sh_bmin, sh_bmax;
  logic [10:0] pub_box;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge i_clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p);
    src[src_len] = p;
    src_len++;
  endtask

  function automatic bit calc_ae();
    int avail;
    avail = src_len - ptr - ((o_rd === 1'b1) ? 1 : 0);
    return force_ae || (avail < 1);
  endfunction

  task automatic set_thr(input int rl, input int rh, input int gl, input int gh, input int bl, input int bh);
    i_rmin = 5'(rl); i_rmax = 5'(rh);
    i_gmin = 6'(gl); i_gmax = 6'(gh);
    i_bmin = 5'(bl); i_bmax = 5'(bh);
  endtask

  task automatic model_reset();
    pos = 0; m_count = 0; mx0 = 0; mx1 = 0; my0 = 0; my1 = 0;
    sh_rmin = 0; sh_rmax = 0; sh_gmin = 0; sh_gmax = 0; sh_bmin = 0; sh_bmax = 0;
    pub_box = '0;
    exp_q.delete();
  endtask

  // Reference: what the pixel at raster index pos must produce
  task automatic model_step(input logic [15:0] p, input int rc);
    exp_t e;
    int x, y, r, g, b;
    bit m;
    x = pos % LL;
    y = pos / LL;
    if (pos == 0) begin
      sh_rmin = int'(i_rmin); sh_rmax = int'(i_rmax);
      sh_gmin = int'(i_gmin); sh_gmax = int'(i_gmax);
      sh_bmin = int'(i_bmin); sh_bmax = int'(i_bmax);
    end
    r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
    m = i_enable && r >= sh_rmin && r <= sh_rmax && g >= sh_gmin && g <= sh_gmax &&
        b >= sh_bmin && b <= sh_bmax;
    e.data = (!i_enable) ? p : (m ? p : 16'h0000);
    if (m) begin
      if (m_count == 0) begin
        mx0 = x; mx1 = x; my0 = y; my1 = y;
      end else begin
        if (x < mx0) mx0 = x;
        if (x > mx1) mx1 = x;
        if (y < my0) my0 = y;
        if (y > my1) my1 = y;
      end
      m_count++;
    end
    e.eof = (pos == FR - 1);
    e.box = {(m_count > 0), mx0[XW-1:0], mx1[XW-1:0], my0[YW-1:0], my1[YW-1:0], m_count[CW-1:0]};
    e.cyc = rc + 2;
    exp_q.push_back(e);
    if (e.eof) begin
      m_count = 0; mx0 = 0; mx1 = 0; my0 = 0; my1 = 0;
    end
    pos = (pos + 1) % FR;
  endtask

  // Upstream buffer: serve a pixel the cycle after each read strobe
  initial begin
    pres_valid = 0; rd_seen = 0; i_data = 16'h0; i_almostempty = 1'b1;
    forever begin
      @(negedge i_clk);
      if (pres_valid) model_step(cur_pix, cur_rc);
      rd_seen  = (o_rd === 1'b1);
      seen_cyc = cyc;
      i_almostempty = calc_ae();
      @(posedge i_clk);
      #1;
      pres_valid = rd_seen;
      if (rd_seen) begin
        chk("upstream_underflow", 32'(ptr < src_len), 32'd1);
        if (ptr < src_len) begin
          cur_pix = src[ptr];
          rd_log[ptr] = seen_cyc;
          ptr++;
        end else begin
          cur_pix = 16'hDEAD;
        end
        cur_rc = seen_cyc;
        i_data = cur_pix;
      end else begin
        i_data = 16'($urandom);
      end
      i_almostempty = calc_ae();
    end
  end

  // Compare process: every output pixel and the held box outputs, every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got o_valid=1, expected no output (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("o_data", 32'(o_data), 32'(e.data));
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("bbox_valid_at_pixel", 32'(o_bbox_valid), 32'(e.eof));
          if (e.eof) pub_box = e.box;
          out_log[out_n] = o_data;
          out_cyc[out_n] = cyc;
          out_n++;
        end
      end else begin
        chk("bbox_valid_idle", 32'(o_bbox_valid), 32'd0);
      end
      chk("bbox_outputs", 32'({o_bbox_found, o_xmin, o_xmax, o_ymin, o_ymax, o_match_count}),
          32'(pub_box));
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (!(ptr == src_len && !pres_valid && !rd_seen && o_rd === 1'b0 && exp_q.size() == 0) &&
           n < 300) begin
      tick();
      n++;
    end
    chk("drain_complete", 32'(n < 300), 32'd1);
    tick();
    tick();
  endtask

  task automatic chk_box(input string name, input int found, input int x0, input int x1,
                         input int y0, input int y1, input int cnt);
    chk({name, "_found"}, 32'(o_bbox_found), 32'(found));
    chk({name, "_xmin"}, 32'(o_xmin), 32'(x0));
    chk({name, "_xmax"}, 32'(o_xmax), 32'(x1));
    chk({name, "_ymin"}, 32'(o_ymin), 32'(y0));
    chk({name, "_ymax"}, 32'(o_ymax), 32'(y1));
    chk({name, "_count"}, 32'(o_match_count), 32'(cnt));
  endtask

  initial begin
    logic [15:0] pat[0:3];
    int run, n, vcount, rdcount;
    pat[0] = 16'hA285; pat[1] = 16'h7BCA; pat[2] = 16'h0000; pat[3] = 16'hF800;
    tests = 0; fails = 0; out_n = 0; src_len = 0; ptr = 0; force_ae = 0;
    model_reset();
    i_rstn = 1'b0; i_enable = 1'b0; i_flush = 1'b0; i_almostfull = 1'b0;
    set_thr(10, 20, 20, 40, 5, 15);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_o_rd", 32'(o_rd), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_count", 32'(o_match_count), 32'd0);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    i_enable = 1'b1;

    // frame 0: boundary match at (0,0), red-out at (1,0), final-pixel match at (3,1)
    push(16'hA285); push(16'hF800);
    repeat (5) push(16'h0000);
    push(16'h7BCA);
    drain();
    chk("first_pixel_data", 32'(out_log[0]), 32'hA285);
    chk("second_pixel_data", 32'(out_log[1]), 32'h0000);
    chk("first_latency", 32'(out_cyc[0] - rd_log[0]), 32'd2);
    chk_box("f0", 1, 0, 3, 0, 1, 2);

    // frame 1: matches only at (1,0) and (2,1)
    push(16'h0000); push(16'hA285); push(16'h0000); push(16'h0000);
    push(16'h0000); push(16'h0000); push(16'h7BCA); push(16'h0000);
    drain();
    chk_box("f1", 1, 1, 2, 0, 1, 2);

    // frame 2: every pixel just outside a window
    push(16'h4A85); push(16'hA265); push(16'hA290); push(16'hF800);
    push(16'h0000); push(16'hFFFF); push(16'h4A85); push(16'hA265);
    drain();
    chk_box("f2", 0, 0, 0, 0, 0, 0);

    // frame 3: passthrough with in-window pixels
    i_enable = 1'b0;
    for (int i = 0; i < 8; i++) push((i % 2 == 0) ? 16'hA285 : 16'h7BCA);
    drain();
    chk_box("f3", 0, 0, 0, 0, 0, 0);
    chk("pass_data0", 32'(out_log[24]), 32'hA285);
    chk("pass_data1", 32'(out_log[25]), 32'h7BCA);
    i_enable = 1'b1;

    // frame 4: rmin raised after (1,0) must not affect this frame
    push(16'hA285); push(16'hA285);
    drain();
    i_rmin = 5'd31;
    repeat (6) push(16'hA285);
    drain();
    chk_box("f4", 1, 0, 3, 0, 1, 8);

    // frame 5: raised rmin (min>max on red) now in force
    repeat (8) push(16'hA285);
    drain();
    chk_box("f5", 0, 0, 0, 0, 0, 0);
    i_rmin = 5'd10;

    // backpressure and upstream stall over 20 pixels
    for (int i = 0; i < 20; i++) push(pat[i % 4]);
    run = 0; n = 0;
    while (run < 3 && n < 100) begin
      tick();
      run = (o_rd === 1'b1) ? run + 1 : 0;
      n++;
    end
    chk("af_stream_started", 32'(run >= 3), 32'd1);
    i_almostfull = 1'b1;
    vcount = 0; rdcount = 0;
    @(negedge i_clk);
    repeat (8) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) vcount++;
      if (o_rd === 1'b1) rdcount++;
    end
    chk("af_valid_after", 32'(vcount), 32'd2);
    chk("af_rd_stopped", 32'(rdcount), 32'd0);
    tick();
    i_almostfull = 1'b0;
    repeat (4) tick();
    force_ae = 1;
    repeat (5) tick();
    chk("ae_rd_stopped", 32'(o_rd), 32'd0);
    force_ae = 0;
    drain();
    chk_box("f7", 1, 0, 1, 0, 1, 4);

    // flush mid-frame; the next pixel must start a frame and latch open thresholds
    set_thr(0, 31, 0, 63, 0, 31);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    model_reset();
    @(negedge i_clk);
    chk_box("flush", 0, 0, 0, 0, 0, 0);
    chk("flush_o_valid", 32'(o_valid), 32'd0);
    tick();
    repeat (8) push(16'h0000);
    drain();
    chk_box("post_flush", 1, 0, 3, 0, 1, 8);

    // asynchronous reset mid-line
    repeat (3) push(16'hA285);
    drain();
    #2;
    i_rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_o_rd", 32'(o_rd), 32'd0);
    chk("arst_o_data", 32'(o_data), 32'd0);
    chk_box("arst", 0, 0, 0, 0, 0, 0);
    set_thr(10, 20, 20, 40, 5, 15);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    push(16'hA285);
    repeat (7) push(16'h0000);
    drain();
    chk_box("post_reset", 1, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
